// File: rtl/song_playback_ctrl.sv
// Transport controller for note-series playback: tempo stepping, play/pause/stop,
// and live-keypad preemption of the song with automatic resume after a silence hold-off.
module song_playback_ctrl #(
    parameter int DIV_BASE = 1000,
    parameter int SONG_LEN = 260,
    parameter int HOLD     = 2000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       play_edge,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [1:0] tempo_sel,
    input  logic [3:0] live_note,
    input  logic [3:0] song_note,
    output logic [3:0] note_out,
    output logic [8:0] song_pos,
    output logic       step,
    output logic       done,
    output logic [1:0] state
);

    localparam int TICK_W = $clog2(4 * DIV_BASE + 1);
    localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [TICK_W-1:0] PERIOD_M1_0 = TICK_W'(DIV_BASE - 1);
    localparam logic [TICK_W-1:0] PERIOD_M1_1 = TICK_W'(2 * DIV_BASE - 1);
    localparam logic [TICK_W-1:0] PERIOD_M1_2 = TICK_W'(3 * DIV_BASE - 1);
    localparam logic [TICK_W-1:0] PERIOD_M1_3 = TICK_W'(4 * DIV_BASE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD);
    localparam logic [8:0]        LAST_POS    = 9'(SONG_LEN - 1);
    localparam logic [3:0]        NOTE_NONE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_LIVE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        pos_q, pos_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        note_q, note_d;
    logic              step_q, step_d;
    logic              done_q, done_d;

    logic [TICK_W-1:0] period_m1;
    logic              live_act;

    assign live_act = (live_note != NOTE_NONE);

    // Tempo is sampled every cycle, so a faster tempo steps on the very next cycle.
    always_comb begin
        case (tempo_sel)
            2'd0:    period_m1 = PERIOD_M1_0;
            2'd1:    period_m1 = PERIOD_M1_1;
            2'd2:    period_m1 = PERIOD_M1_2;
            default: period_m1 = PERIOD_M1_3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        if (live_act) begin
            note_d = live_note;
        end else if (state_q == S_PLAY) begin
            note_d = song_note;
        end else begin
            note_d = NOTE_NONE;
        end

        if (stop) begin
            state_d = S_IDLE;
            pos_d   = '0;
            tick_d  = '0;
        end else if (play_edge) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PLAY;
                    pos_d   = '0;
                    tick_d  = '0;
                end
                S_PLAY:  state_d = S_PAUSE;
                S_PAUSE: state_d = S_PLAY;
                default: state_d = S_PAUSE;
            endcase
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (live_act) begin
                        state_d = S_LIVE;
                        hold_d  = HOLD_LOAD;
                    end else if (tick_q >= period_m1) begin
                        tick_d = '0;
                        if (pos_q < LAST_POS) begin
                            pos_d  = pos_q + 9'd1;
                            step_d = 1'b1;
                        end else if (loop_en) begin
                            pos_d  = '0;
                            step_d = 1'b1;
                        end else begin
                            pos_d   = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_LIVE: begin
                    // Song resumes only after HOLD+1 consecutive silent cycles.
                    if (live_act) begin
                        hold_d = HOLD_LOAD;
                    end else if (hold_q == '0) begin
                        state_d = S_PLAY;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            tick_q  <= '0;
            hold_q  <= '0;
            note_q  <= NOTE_NONE;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            note_q  <= note_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign note_out = note_q;
    assign song_pos = pos_q;
    assign step     = step_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule
